return_stack: RTL and testbench

//  Parametrised hardware return-address stack for the pipelined RISC core. Successor to the

---
 rtl/return_stack_pkg.sv | 26 ++
 rtl/return_stack_mem.sv | 38 +++
 rtl/return_stack.sv | 210 +++++++++++++++++++++
 tb/tb_return_stack.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/return_stack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : return_stack_pkg
//  Description : Shared definitions for the return-address stack: entry-kind
//                tags, default PC/flag widths matching the core, and the
//                packed entry width helper.
//                Entry layout (MSB..LSB): {kind, flags, adr}
//  Revision    : 1.0 - initial release
// ============================================================================
package return_stack_pkg;

    // Entry-kind tag values
    localparam logic c_kind_call = 1'b0;
    localparam logic c_kind_isr  = 1'b1;

    // Default widths matching the core program counter and NZCV flags
    localparam int c_def_addr_width = 12;
    localparam int c_def_flag_width = 4;

    // Width of one packed stack entry {kind, flags, adr}
    function automatic int entry_width(input int addr_width, input int flag_width);
        return 1 + flag_width + addr_width;
    endfunction

endpackage : return_stack_pkg
`default_nettype wire

// File: rtl/return_stack_mem.sv
`default_nettype none
// ============================================================================
//  Module      : return_stack_mem
//  Description : DEPTH x WIDTH register file backing the return stack.
//                One synchronous write port, one asynchronous read port.
//                Contents are not reset; validity is tracked by the owner.
//  Ports       : clk      - system clock
//                i_we     - write enable
//                i_waddr  - write address
//                i_wdata  - write data
//                i_raddr  - read address
//                o_rdata  - read data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module return_stack_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : return_stack_mem
`default_nettype wire

// File: rtl/return_stack.sv
`default_nettype none
// ============================================================================
//  Module      : return_stack
//  Description : Parametrised return-address stack for the pipelined core.
//                Holds subroutine (CALL) and interrupt (ISR) return contexts
//                in a circular buffer, with an optional wrap-on-overflow
//                policy and sticky overflow/underflow/kind-mismatch flags.
//  Ports       : clock, reset            - clock, synchronous active-high reset
//                stall                   - suppresses all push/pop requests
//                push_call, push_isr     - push strobes (ISR wins if both)
//                pop_rts, pop_rti        - pop strobes (RTI wins if both)
//                push_adr, push_flags    - context to save
//                clear_err               - clears sticky error flags
//                top_adr/flags/is_isr    - top entry view (0 when empty)
//                count, empty, full      - occupancy
//                overflow, underflow,
//                kind_err                - sticky error flags
//  Revision    : 1.0 - initial release
// ============================================================================
module return_stack
    import return_stack_pkg::*;
#(
    parameter int ADDR_WIDTH = c_def_addr_width,
    parameter int DEPTH      = 16,
    parameter int FLAG_WIDTH = c_def_flag_width,
    parameter int WRAP_MODE  = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     push_call,
    input  logic                     push_isr,
    input  logic                     pop_rts,
    input  logic                     pop_rti,
    input  logic [ADDR_WIDTH-1:0]    push_adr,
    input  logic [FLAG_WIDTH-1:0]    push_flags,
    input  logic                     clear_err,
    output logic [ADDR_WIDTH-1:0]    top_adr,
    output logic [FLAG_WIDTH-1:0]    top_flags,
    output logic                     top_is_isr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     kind_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = entry_width(ADDR_WIDTH, FLAG_WIDTH);

    localparam logic [CW-1:0] c_full_count = CW'(DEPTH);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [PW-1:0] r_wp;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_underflow;
    logic          r_kind_err;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [PW-1:0]         w_top_ptr;
    logic [EW-1:0]         w_rd_entry;
    logic [EW-1:0]         w_wr_entry;
    logic [PW-1:0]         w_waddr;
    logic                  w_we;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_push_kind;
    logic                  w_pop_kind;
    logic                  w_top_kind;
    logic                  w_wrap_write;
    logic [FLAG_WIDTH-1:0] w_push_flags;
    logic [PW-1:0]         w_wp_nxt;
    logic [CW-1:0]         w_count_nxt;
    logic                  w_set_ovf;
    logic                  w_set_unf;
    logic                  w_set_kerr;

    // Overflow policy: whether a push into a full stack still writes
    generate
        if (WRAP_MODE != 0) begin : g_wrap
            assign w_wrap_write = 1'b1;
        end else begin : g_refuse
            assign w_wrap_write = 1'b0;
        end
    endgenerate

    // Top entry sits one below the write pointer; PW-bit arithmetic wraps
    assign w_top_ptr = r_wp - PW'(1);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_full_count);

    assign w_push      = ~stall & (push_call | push_isr);
    assign w_pop       = ~stall & (pop_rts | pop_rti);
    assign w_push_kind = push_isr ? c_kind_isr : c_kind_call;
    assign w_pop_kind  = pop_rti ? c_kind_isr : c_kind_call;
    assign w_top_kind  = w_rd_entry[EW-1];

    // Subroutine entries never carry flags
    assign w_push_flags = (w_push_kind == c_kind_isr) ? push_flags : '0;
    assign w_wr_entry   = {w_push_kind, w_push_flags, push_adr};

    // ------------------------------------------------------------------
    // Operation decode
    // ------------------------------------------------------------------
    always_comb begin
        w_we        = 1'b0;
        w_waddr     = r_wp;
        w_wp_nxt    = r_wp;
        w_count_nxt = r_count;
        w_set_ovf   = 1'b0;
        w_set_unf   = 1'b0;
        w_set_kerr  = 1'b0;

        if (w_push && w_pop) begin
            if (w_empty) begin
                // Nothing to pop; the push still lands as the only entry
                w_set_unf   = 1'b1;
                w_we        = 1'b1;
                w_wp_nxt    = r_wp + PW'(1);
                w_count_nxt = r_count + CW'(1);
            end else begin
                // Replace the top in place; occupancy unchanged, so never overflow
                w_we       = 1'b1;
                w_waddr    = w_top_ptr;
                w_set_kerr = (w_top_kind != w_pop_kind);
            end
        end else if (w_push) begin
            if (w_full) begin
                w_set_ovf = 1'b1;
                if (w_wrap_write) begin
                    // When full, wp addresses the oldest entry, which is overwritten
                    w_we     = 1'b1;
                    w_wp_nxt = r_wp + PW'(1);
                end
            end else begin
                w_we        = 1'b1;
                w_wp_nxt    = r_wp + PW'(1);
                w_count_nxt = r_count + CW'(1);
            end
        end else if (w_pop) begin
            if (w_empty) begin
                w_set_unf = 1'b1;
            end else begin
                w_wp_nxt    = w_top_ptr;
                w_count_nxt = r_count - CW'(1);
                w_set_kerr  = (w_top_kind != w_pop_kind);
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wp        <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_kind_err  <= 1'b0;
        end else begin
            r_wp        <= w_wp_nxt;
            r_count     <= w_count_nxt;
            // A new error in the same cycle as clear_err keeps the flag set
            r_overflow  <= w_set_ovf  | (r_overflow  & ~clear_err);
            r_underflow <= w_set_unf  | (r_underflow & ~clear_err);
            r_kind_err  <= w_set_kerr | (r_kind_err  & ~clear_err);
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    return_stack_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk     (clock),
        .i_we    (w_we & ~reset),
        .i_waddr (w_waddr),
        .i_wdata (w_wr_entry),
        .i_raddr (w_top_ptr),
        .o_rdata (w_rd_entry)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign top_adr    = w_empty ? '0 : w_rd_entry[ADDR_WIDTH-1:0];
    assign top_is_isr = w_empty ? 1'b0 : w_top_kind;
    assign top_flags  = (w_empty || (w_top_kind == c_kind_call)) ? '0
                      : w_rd_entry[ADDR_WIDTH+FLAG_WIDTH-1:ADDR_WIDTH];
    assign count      = r_count;
    assign empty      = w_empty;
    assign full       = w_full;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;
    assign kind_err   = r_kind_err;

endmodule : return_stack
`default_nettype wire

// File: tb/tb_return_stack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_return_stack
//  Description : Directed self-checking bench for return_stack. Two instances
//                share all inputs: u_dut refuses pushes when full, u_dut_w
//                overwrites the oldest entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_return_stack;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        push_call;
    logic        push_isr;
    logic        pop_rts;
    logic        pop_rti;
    logic [11:0] push_adr;
    logic [3:0]  push_flags;
    logic        clear_err;

    logic [11:0] top_adr,    top_adr_w;
    logic [3:0]  top_flags,  top_flags_w;
    logic        top_is_isr, top_is_isr_w;
    logic [4:0]  count,      count_w;
    logic        empty,      empty_w;
    logic        full,       full_w;
    logic        overflow,   overflow_w;
    logic        underflow,  underflow_w;
    logic        kind_err,   kind_err_w;

    int n_cmp;
    int n_err;

    return_stack #(
        .ADDR_WIDTH (12),
        .DEPTH      (16),
        .FLAG_WIDTH (4),
        .WRAP_MODE  (0)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .stall      (stall),
        .push_call  (push_call),
        .push_isr   (push_isr),
        .pop_rts    (pop_rts),
        .pop_rti    (pop_rti),
        .push_adr   (push_adr),
        .push_flags (push_flags),
        .clear_err  (clear_err),
        .top_adr    (top_adr),
        .top_flags  (top_flags),
        .top_is_isr (top_is_isr),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow),
        .kind_err   (kind_err)
    );

    return_stack #(
        .ADDR_WIDTH (12),
        .DEPTH      (16),
        .FLAG_WIDTH (4),
        .WRAP_MODE  (1)
    ) u_dut_w (
        .clock      (clock),
        .reset      (reset),
        .stall      (stall),
        .push_call  (push_call),
        .push_isr   (push_isr),
        .pop_rts    (pop_rts),
        .pop_rti    (pop_rti),
        .push_adr   (push_adr),
        .push_flags (push_flags),
        .clear_err  (clear_err),
        .top_adr    (top_adr_w),
        .top_flags  (top_flags_w),
        .top_is_isr (top_is_isr_w),
        .count      (count_w),
        .empty      (empty_w),
        .full       (full_w),
        .overflow   (overflow_w),
        .underflow  (underflow_w),
        .kind_err   (kind_err_w)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of requests, then release; outputs settle #1 after the edge
    task automatic op(input logic pc, input logic pi, input logic pr, input logic prti,
                      input logic [11:0] adr, input logic [3:0] flg, input logic clr,
                      input logic stl);
        push_call  = pc;
        push_isr   = pi;
        pop_rts    = pr;
        pop_rti    = prti;
        push_adr   = adr;
        push_flags = flg;
        clear_err  = clr;
        stall      = stl;
        @(posedge clock);
        #1;
        push_call = 0; push_isr = 0; pop_rts = 0; pop_rti = 0;
        push_adr = '0; push_flags = '0; clear_err = 0; stall = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        push_call = 1'b1; push_adr = 12'h3FF;
        @(posedge clock);
        #1;
        reset = 1'b0; push_call = 1'b0; push_adr = '0;
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
        n_cmp++; if ({top_adr, top_flags, top_is_isr} !== 17'd0) begin n_err++; $display("FAIL reset_top got %h/%b/%b want 0", top_adr, top_flags, top_is_isr); end
        n_cmp++; if ({overflow, underflow, kind_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {overflow, underflow, kind_err}); end
    endtask

    task automatic test_call_return();
        do_reset();
        op(1, 0, 0, 0, 12'h010, 4'h0, 0, 0);
        n_cmp++; if (top_adr !== 12'h010) begin n_err++; $display("FAIL push1_latency got %h want 010", top_adr); end
        op(1, 0, 0, 0, 12'h020, 4'h0, 0, 0);
        op(1, 0, 0, 0, 12'h030, 4'h0, 0, 0);
        n_cmp++; if (count !== 5'd3) begin n_err++; $display("FAIL call3_count got %0d want 3", count); end
        n_cmp++; if (top_adr !== 12'h030) begin n_err++; $display("FAIL call3_top got %h want 030", top_adr); end
        n_cmp++; if (top_is_isr !== 1'b0) begin n_err++; $display("FAIL call3_kind got %b want 0", top_is_isr); end
        op(0, 0, 1, 0, 12'h000, 4'h0, 0, 0);
        n_cmp++; if (top_adr !== 12'h020) begin n_err++; $display("FAIL rts1_top got %h want 020", top_adr); end
        op(0, 0, 1, 0, 12'h000, 4'h0, 0, 0);
        n_cmp++; if (top_adr !== 12'h010) begin n_err++; $display("FAIL rts2_top got %h want 010", top_adr); end
        op(0, 0, 1, 0, 12'h000, 4'h0, 0, 0);
        n_cmp++; if (empty !== 1'b1 || top_adr !== 12'h000) begin n_err++; $display("FAIL rts3_empty got empty=%b top=%h want 1/000", empty, top_adr); end
        n_cmp++; if ({overflow, underflow, kind_err} !== 3'b000) begin n_err++; $display("FAIL rts_flags got %b want 000", {overflow, underflow, kind_err}); end
    endtask

    task automatic test_isr_kind();
        do_reset();
        op(0, 1, 0, 0, 12'h0A5, 4'b1010, 0, 0);
        n_cmp++; if (top_is_isr !== 1'b1) begin n_err++; $display("FAIL isr_kind got %b want 1", top_is_isr); end
        n_cmp++; if (top_flags !== 4'b1010) begin n_err++; $display("FAIL isr_flags got %b want 1010", top_flags); end
        n_cmp++; if (top_adr !== 12'h0A5) begin n_err++; $display("FAIL isr_adr got %h want 0a5", top_adr); end
        op(0, 0, 1, 0, 12'h000, 4'h0, 0, 0);
        n_cmp++; if (kind_err !== 1'b1) begin n_err++; $display("FAIL rts_on_isr_kerr got %b want 1", kind_err); end
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL rts_on_isr_count got %0d want 0", count); end
        op(0, 0, 0, 0, 12'h000, 4'h0, 1, 0);
        n_cmp++; if (kind_err !== 1'b0) begin n_err++; $display("FAIL clear_kerr got %b want 0", kind_err); end
        // Call entry pushed with flags must store zero flags
        op(1, 0, 0, 0, 12'h0B6, 4'b1111, 0, 0);
        n_cmp++; if (top_flags !== 4'b0000) begin n_err++; $display("FAIL call_flags_zero got %b want 0000", top_flags); end
        // Both push strobes: ISR wins
        op(1, 1, 0, 0, 12'h0C7, 4'b0101, 0, 0);
        n_cmp++; if (top_is_isr !== 1'b1 || top_flags !== 4'b0101) begin n_err++; $display("FAIL push_both got kind=%b flags=%b want 1/0101", top_is_isr, top_flags); end
        // Both pop strobes: treated as RTI on ISR top, no error
        op(0, 0, 1, 1, 12'h000, 4'h0, 0, 0);
        n_cmp++; if (kind_err !== 1'b0 || top_adr !== 12'h0B6) begin n_err++; $display("FAIL pop_both got kerr=%b top=%h want 0/0b6", kind_err, top_adr); end
        // pop_rti on call top with clear_err same cycle: set wins
        op(0, 0, 0, 1, 12'h000, 4'h0, 1, 0);
        n_cmp++; if (kind_err !== 1'b1) begin n_err++; $display("FAIL set_over_clear got %b want 1", kind_err); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            op(1, 0, 0, 0, 12'h100 + 12'(i), 4'h0, 0, 0);
        end
        n_cmp++; if (full !== 1'b1 || overflow !== 1'b1) begin n_err++; $display("FAIL refuse_full_ovf got %b%b want 11", full, overflow); end
        n_cmp++; if (top_adr !== 12'h10F) begin n_err++; $display("FAIL refuse_top got %h want 10f", top_adr); end
        n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL refuse_count got %0d want 16", count); end
        n_cmp++; if (top_adr_w !== 12'h110) begin n_err++; $display("FAIL wrap_top got %h want 110", top_adr_w); end
        n_cmp++; if (count_w !== 5'd16 || overflow_w !== 1'b1) begin n_err++; $display("FAIL wrap_count_ovf got %0d/%b want 16/1", count_w, overflow_w); end
        for (int i = 0; i < 15; i++) begin
            op(0, 0, 1, 0, 12'h000, 4'h0, 0, 0);
        end
        n_cmp++; if (top_adr_w !== 12'h101 || count_w !== 5'd1) begin n_err++; $display("FAIL wrap_last got %h/%0d want 101/1", top_adr_w, count_w); end
        n_cmp++; if (top_adr !== 12'h100) begin n_err++; $display("FAIL refuse_last got %h want 100", top_adr); end
        op(0, 0, 1, 0, 12'h000, 4'h0, 0, 0);
        n_cmp++; if (empty !== 1'b1 || empty_w !== 1'b1) begin n_err++; $display("FAIL drain_empty got %b%b want 11", empty, empty_w); end
        n_cmp++; if (underflow !== 1'b0 || underflow_w !== 1'b0) begin n_err++; $display("FAIL drain_unf got %b%b want 00", underflow, underflow_w); end
    endtask

    task automatic test_underflow();
        do_reset();
        op(0, 0, 0, 1, 12'h000, 4'h0, 0, 0);
        n_cmp++; if (underflow !== 1'b1 || count !== 5'd0) begin n_err++; $display("FAIL unf_pop got %b/%0d want 1/0", underflow, count); end
        op(0, 0, 0, 0, 12'h000, 4'h0, 1, 0);
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL unf_clear got %b want 0", underflow); end
        op(1, 0, 1, 0, 12'h055, 4'h0, 0, 0);
        n_cmp++; if (count !== 5'd1 || top_adr !== 12'h055) begin n_err++; $display("FAIL empty_pushpop got %0d/%h want 1/055", count, top_adr); end
        n_cmp++; if (underflow !== 1'b1 || kind_err !== 1'b0) begin n_err++; $display("FAIL empty_pushpop_flags got unf=%b kerr=%b want 1/0", underflow, kind_err); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        op(1, 0, 0, 0, 12'h040, 4'h0, 0, 0);
        op(1, 0, 1, 0, 12'h077, 4'h0, 0, 0);
        n_cmp++; if (count !== 5'd1 || top_adr !== 12'h077) begin n_err++; $display("FAIL replace got %0d/%h want 1/077", count, top_adr); end
        n_cmp++; if (kind_err !== 1'b0) begin n_err++; $display("FAIL replace_kerr got %b want 0", kind_err); end
        op(0, 1, 0, 1, 12'h123, 4'hF, 0, 1);
        n_cmp++; if (count !== 5'd1 || top_adr !== 12'h077 || top_is_isr !== 1'b0) begin n_err++; $display("FAIL stall got %0d/%h/%b want 1/077/0", count, top_adr, top_is_isr); end
        n_cmp++; if ({overflow, underflow, kind_err} !== 3'b000) begin n_err++; $display("FAIL stall_flags got %b want 000", {overflow, underflow, kind_err}); end
        // Fill to full, then push+pop: replacement, no overflow
        for (int i = 0; i < 15; i++) begin
            op(1, 0, 0, 0, 12'h200 + 12'(i), 4'h0, 0, 0);
        end
        op(0, 1, 1, 0, 12'h2AA, 4'h3, 0, 0);
        n_cmp++; if (count !== 5'd16 || top_adr !== 12'h2AA || overflow !== 1'b0) begin n_err++; $display("FAIL full_replace got %0d/%h/%b want 16/2aa/0", count, top_adr, overflow); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            op(1, 0, 0, 0, 12'h300 + 12'(i), 4'h0, 0, 0);
        end
        op(0, 0, 0, 1, 12'h000, 4'h0, 0, 0);
        n_cmp++; if (count !== 5'd5 || kind_err !== 1'b1) begin n_err++; $display("FAIL mid_setup got %0d/%b want 5/1", count, kind_err); end
        reset = 1'b1; push_call = 1'b1; push_adr = 12'h3AB;
        @(posedge clock);
        #1;
        reset = 1'b0; push_call = 1'b0; push_adr = '0;
        n_cmp++; if (count !== 5'd0 || empty !== 1'b1) begin n_err++; $display("FAIL mid_reset got %0d/%b want 0/1", count, empty); end
        n_cmp++; if ({overflow, underflow, kind_err} !== 3'b000) begin n_err++; $display("FAIL mid_reset_flags got %b want 000", {overflow, underflow, kind_err}); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 0; stall = 0; push_call = 0; push_isr = 0; pop_rts = 0; pop_rti = 0;
        push_adr = '0; push_flags = '0; clear_err = 0;
        @(negedge clock);
        test_reset();
        test_call_return();
        test_isr_kind();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_return_stack
`default_nettype wire
